layer_three_dense: RTL and testbench
====================================

Name: layer_three_dense

Overview:
- Final binary dense layer; the consumer of the 4x7x7 pooled map that layer_two produces.
- Runs while the top-level state is s_LAYER_3 (3'b100).
- For each of NUM_CLASSES classes it XNOR-popcounts the 196-bit flattened feature map against that class's 196-bit weight vector, then takes the argmax.
- Weights are streamed in CHUNK_W-bit words from an external weight memory over a req/valid handshake.

Parameters:
- NUM_CLASSES, 10, number of output classes (1..16).
- CHUNK_W, 28, weight word width; must divide 196; NCHUNK = 196/CHUNK_W (default 7).
- ADDR_W, 7, weight address width; 2^ADDR_W must be >= NUM_CLASSES*NCHUNK.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- state  in  3  top-level FSM state; the block runs only while this equals 3'b100.
- feature  in  [3:0][6:0][6:0]  layer_two output; held stable throughout s_LAYER_3.
- wt_req  out  1  weight word request.
- wt_addr  out  ADDR_W  weight word address = class*NCHUNK + chunk.
- wt_data  in  CHUNK_W  weight word.
- wt_valid  in  1  wt_data is valid for the current wt_addr.
- class_out  out  4  winning class index.
- done  out  1  result valid; sticky until rst.

Behaviour:
- Reset (rst=1 at a rising edge, dominant over everything):
  - FSM goes to IDLE; class, chunk, acc, best_score and best_class clear to 0.
  - Outputs: wt_req=0, wt_addr=0, class_out=0, done=0.
- Flattening: bit i = (f*49 + r*7 + c) holds feature[f][r][c]. Chunk k covers bits [k*CHUNK_W +: CHUNK_W]. Bit j of wt_data pairs with flattened bit k*CHUNK_W+j.
- FSM states: IDLE, FETCH, CMP, DONE.
  - IDLE:
    - If state==3'b100, go to FETCH with class=0, chunk=0, acc=0.
    - Otherwise stay.
  - FETCH:
    - wt_req=1; wt_addr is registered and stable until accepted.
    - A transfer occurs on an edge where wt_req and wt_valid are both 1.
    - On a transfer: acc += popcount(~(chunk_bits ^ wt_data)).
    - If chunk==NCHUNK-1, go to CMP; otherwise chunk++.
    - If wt_valid=0, hold: no accumulation, address unchanged.
  - CMP:
    - wt_req=0.
    - If class==0 or acc > best_score (strictly greater): best_score=acc, best_class=class.
    - Ties keep the lower class index.
    - If class==NUM_CLASSES-1: go to DONE, drive class_out from the updated best_class, set done=1.
    - Otherwise: class++, chunk=0, acc=0, go to FETCH.
  - DONE:
    - done=1 and class_out held; wt_req=0.
    - Stays in DONE regardless of state; leaves only on rst.
- Abort: if state != 3'b100 while in FETCH or CMP, the next edge returns to IDLE, clears counters and acc, and leaves done=0 and class_out unchanged. Re-entering s_LAYER_3 restarts from class 0.
- Widths:
  - acc and best_score are 8 bits (max 196); no overflow possible.
  - Popcount is computed combinationally per chunk.
- Latency with wt_valid tied to 1:
  - Edge 1 is the IDLE->FETCH edge.
  - Each class takes NCHUNK+1 edges.
  - done rises on edge 1 + NUM_CLASSES*(NCHUNK+1) = 81 for the defaults.
  - Each cycle where a request is stalled (wt_valid=0) adds one edge.
- The block never requests an address >= NUM_CLASSES*NCHUNK.

Optional Feature:
- Macro: LAYER3_SCORE_EN.
- Defined:
  - Adds output port best_score_out[7:0].
  - Reset value 0; registered alongside class_out on the CMP->DONE edge; held with done.
- Undefined:
  - Port absent; best_score is internal only.
  - All other behaviour identical.

Test Plan:
- Feature all 0, every weight word 0, wt_valid=1 -> all scores 196 (tie), class_out=0, done rises on edge 81, score 196 (LAYER3_SCORE_EN).
- Random feature; class 7 weights = feature, all other classes = ~feature -> class_out=7, score 196; wt_addr sequence 0..69 observed in order, one per FETCH cycle.
- Same as the previous test but wt_valid deasserted for 2 cycles before every accept -> identical result; done on edge 81+140=221; wt_addr stable during stalls.
- Class 3 and class 5 both score 150, all others 100 -> class_out=3.
- rst=1 during class 4 FETCH, then rerun -> all outputs 0 after reset edge; rerun gives correct class, done on edge 81 of the new run.
- state leaves 3'b100 during class 2 -> IDLE, done=0, wt_req=0 next cycle; on re-entry wt_addr restarts at 0.

Source files
------------

// File: rtl/layer_three_dense.sv
// ============================================================================
// Module   : layer_three_dense
// Brief    : Final binary dense layer. XNOR-popcounts the 196-bit pooled map
//            against streamed per-class weight vectors and reports the argmax.
//            Optional macro LAYER3_SCORE_EN exposes the winning score.
// Revision : 1.0
// ============================================================================
`default_nettype none

module layer_three_dense #(
  parameter int NUM_CLASSES = 10,
  parameter int CHUNK_W     = 28,
  parameter int ADDR_W      = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2:0]                  state,
  input  logic [3:0][6:0][6:0]        feature,
  output logic                        wt_req,
  output logic [ADDR_W-1:0]           wt_addr,
  input  logic [CHUNK_W-1:0]          wt_data,
  input  logic                        wt_valid,
  output logic [3:0]                  class_out,
  output logic                        done
`ifdef LAYER3_SCORE_EN
  ,
  output logic [7:0]                  best_score_out
`endif
);

  localparam int c_NBITS    = 196;
  localparam int c_NCHUNK   = c_NBITS / CHUNK_W;
  localparam int c_CHUNK_BW = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;

  localparam logic [2:0]            c_S_LAYER_3  = 3'b100;
  localparam logic [c_CHUNK_BW-1:0] c_LAST_CHUNK = c_CHUNK_BW'(c_NCHUNK - 1);
  localparam logic [3:0]            c_LAST_CLASS = 4'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_CMP   = 2'd2,
    S_DONE  = 2'd3
  } fsm_state_t;

  fsm_state_t              r_fsm;
  fsm_state_t              w_fsm_nxt;

  logic [3:0]              r_class;
  logic [c_CHUNK_BW-1:0]   r_chunk;
  logic [7:0]              r_acc;
  logic [7:0]              r_best_score;
  logic [3:0]              r_best_class;
  logic [ADDR_W-1:0]       r_wt_addr;
  logic [3:0]              r_class_out;
  logic                    r_done;
`ifdef LAYER3_SCORE_EN
  logic [7:0]              r_best_score_out;
`endif

  logic [c_NBITS-1:0]      w_flat;
  logic [CHUNK_W-1:0]      w_chunk_bits;
  logic [CHUNK_W-1:0]      w_match;
  logic [7:0]              w_pop;
  logic                    w_active;
  logic                    w_xfer;
  logic                    w_last_chunk;
  logic                    w_last_class;
  logic                    w_take;
  logic                    w_req;

  // Packed [f][r][c] ordering already places feature[f][r][c] at f*49+r*7+c.
  assign w_flat = feature;

  always_comb begin
    w_chunk_bits = w_flat[int'(r_chunk) * CHUNK_W +: CHUNK_W];
    w_match      = ~(w_chunk_bits ^ wt_data);
    w_pop        = '0;
    for (int j = 0; j < CHUNK_W; j++) begin
      w_pop = w_pop + 8'(w_match[j]);
    end
  end

  assign w_active     = (state == c_S_LAYER_3);
  assign w_last_chunk = (r_chunk == c_LAST_CHUNK);
  assign w_last_class = (r_class == c_LAST_CLASS);
  // Strict compare so ties keep the earlier (lower) class.
  assign w_take       = (r_class == 4'd0) || (r_acc > r_best_score);
  assign w_xfer       = w_req && wt_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_req     = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (w_active) begin
          w_fsm_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_req = w_active;
        if (!w_active) begin
          w_fsm_nxt = S_IDLE;
        end else if (w_xfer && w_last_chunk) begin
          w_fsm_nxt = S_CMP;
        end
      end
      S_CMP: begin
        if (!w_active) begin
          w_fsm_nxt = S_IDLE;
        end else if (w_last_class) begin
          w_fsm_nxt = S_DONE;
        end else begin
          w_fsm_nxt = S_FETCH;
        end
      end
      S_DONE: begin
        w_fsm_nxt = S_DONE;
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_class          <= '0;
      r_chunk          <= '0;
      r_acc            <= '0;
      r_best_score     <= '0;
      r_best_class     <= '0;
      r_wt_addr        <= '0;
      r_class_out      <= '0;
      r_done           <= 1'b0;
`ifdef LAYER3_SCORE_EN
      r_best_score_out <= '0;
`endif
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (w_active) begin
            r_class   <= '0;
            r_chunk   <= '0;
            r_acc     <= '0;
            r_wt_addr <= '0;
          end
        end
        S_FETCH: begin
          if (!w_active) begin
            r_class   <= '0;
            r_chunk   <= '0;
            r_acc     <= '0;
            r_wt_addr <= '0;
          end else if (w_xfer) begin
            r_acc <= r_acc + w_pop;
            // Address stays on the last word of the class until CMP moves on.
            if (!w_last_chunk) begin
              r_chunk   <= r_chunk + 1'b1;
              r_wt_addr <= r_wt_addr + 1'b1;
            end
          end
        end
        S_CMP: begin
          if (!w_active) begin
            r_class   <= '0;
            r_chunk   <= '0;
            r_acc     <= '0;
            r_wt_addr <= '0;
          end else begin
            if (w_take) begin
              r_best_score <= r_acc;
              r_best_class <= r_class;
            end
            if (w_last_class) begin
              r_class_out      <= w_take ? r_class : r_best_class;
              r_done           <= 1'b1;
`ifdef LAYER3_SCORE_EN
              r_best_score_out <= w_take ? r_acc : r_best_score;
`endif
            end else begin
              r_class   <= r_class + 4'd1;
              r_chunk   <= '0;
              r_acc     <= '0;
              r_wt_addr <= r_wt_addr + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign wt_req    = w_req;
  assign wt_addr   = r_wt_addr;
  assign class_out = r_class_out;
  assign done      = r_done;
`ifdef LAYER3_SCORE_EN
  assign best_score_out = r_best_score_out;
`endif

endmodule

`default_nettype wire

// File: tb/tb_layer_three_dense.sv
// ============================================================================
// Module   : tb_layer_three_dense
// Brief    : Directed self-checking bench for layer_three_dense with a weight
//            memory responder and an expected-result scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_layer_three_dense;

  localparam int NUM_CLASSES = 10;
  localparam int CHUNK_W     = 28;
  localparam int ADDR_W      = 7;
  localparam int NCHUNK      = 7;
  localparam int NWORDS      = NUM_CLASSES * NCHUNK;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [2:0]           state = 3'b000;
  logic [3:0][6:0][6:0] feature = '0;
  logic                 wt_req;
  logic [ADDR_W-1:0]    wt_addr;
  logic [CHUNK_W-1:0]   wt_data = '0;
  logic                 wt_valid = 1'b0;
  logic [3:0]           class_out;
  logic                 done;
`ifdef LAYER3_SCORE_EN
  logic [7:0]           best_score_out;
`endif

  layer_three_dense #(
    .NUM_CLASSES (NUM_CLASSES),
    .CHUNK_W     (CHUNK_W),
    .ADDR_W      (ADDR_W)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .feature   (feature),
    .wt_req    (wt_req),
    .wt_addr   (wt_addr),
    .wt_data   (wt_data),
    .wt_valid  (wt_valid),
    .class_out (class_out),
    .done      (done)
`ifdef LAYER3_SCORE_EN
    ,
    .best_score_out (best_score_out)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int cls;
    int score;
    int edge_n;
  } exp_t;

  exp_t               exp_q[$];
  int                 addr_q[$];
  logic [CHUNK_W-1:0] wmem [0:127];
  logic [195:0]       feat_v;
  logic [195:0]       wvec [NUM_CLASSES];
  bit                 stall_en = 1'b0;
  int                 scnt = 0;
  bit                 prev_stalled = 1'b0;
  logic [ADDR_W-1:0]  prev_addr = '0;
  int                 start_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [195:0] flip_mask(input int n);
    logic [195:0] m;
    m = (196'(1) << n) - 196'(1);
    return m;
  endfunction

  task automatic load_mem();
    for (int a = 0; a < 128; a++) wmem[a] = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int k = 0; k < NCHUNK; k++) begin
        wmem[c*NCHUNK + k] = wvec[c][k*CHUNK_W +: CHUNK_W];
      end
    end
    feature = feat_v;
  endtask

  task automatic rand_feature();
    for (int i = 0; i < 196; i++) feat_v[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic set_class7_match();
    for (int c = 0; c < NUM_CLASSES; c++) wvec[c] = (c == 7) ? feat_v : ~feat_v;
  endtask

  task automatic set_tie_3_5();
    for (int c = 0; c < NUM_CLASSES; c++)
      wvec[c] = feat_v ^ flip_mask((c == 3 || c == 5) ? 46 : 96);
  endtask

  // Caller is positioned at a negedge.
  task automatic start_run(input int cls, input int score, input int edge_n);
    exp_t e;
    state     = 3'b100;
    start_cyc = cyc;
    addr_q.delete();
    for (int a = 0; a < NWORDS; a++) addr_q.push_back(a);
    e.cls = cls; e.score = score; e.edge_n = edge_n;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_class"}, 32'(class_out), 32'(e.cls));
    chk({tag, "_edge"}, 32'(cyc - start_cyc), 32'(e.edge_n));
`ifdef LAYER3_SCORE_EN
    chk({tag, "_score"}, 32'(best_score_out), 32'(e.score));
`endif
    chk({tag, "_addr_left"}, 32'(addr_q.size()), 32'd0);
  endtask

  task automatic wait_addr(input string tag, input int target);
    int n;
    n = 0;
    while (!(wt_req === 1'b1 && int'(wt_addr) == target) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(wt_addr), 32'(target));
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    state = 3'b000;
    @(negedge clk);
    rst   = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_wt_req"}, 32'(wt_req), 32'd0);
    chk({tag, "_wt_addr"}, 32'(wt_addr), 32'd0);
    chk({tag, "_class_out"}, 32'(class_out), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
`ifdef LAYER3_SCORE_EN
    chk({tag, "_score"}, 32'(best_score_out), 32'd0);
`endif
  endtask

  // Weight memory responder: optional two-cycle stall before every accept,
  // address ordering and stall stability checks.
  initial begin
    forever begin
      int ea;
      @(negedge clk);
      wt_data = wmem[wt_addr];
      if (wt_req === 1'b1) begin
        if (prev_stalled) chk("addr_stable", 32'(wt_addr), 32'(prev_addr));
        if (stall_en && scnt < 2) begin
          wt_valid     = 1'b0;
          scnt++;
          prev_stalled = 1'b1;
        end else begin
          wt_valid     = 1'b1;
          scnt         = 0;
          prev_stalled = 1'b0;
          ea = (addr_q.size() > 0) ? addr_q.pop_front() : -1;
          chk("wt_addr_seq", 32'(wt_addr), 32'(ea));
        end
        prev_addr = wt_addr;
      end else begin
        wt_valid     = 1'b0;
        scnt         = 0;
        prev_stalled = 1'b0;
      end
    end
  end

  initial begin
    for (int a = 0; a < 128; a++) wmem[a] = '0;
    rst   = 1'b1;
    state = 3'b000;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

    // All-zero feature and weights: every class ties at 196.
    feat_v = '0;
    for (int c = 0; c < NUM_CLASSES; c++) wvec[c] = '0;
    load_mem();
    @(negedge clk);
    start_run(0, 196, 81);
    wait_done("zero_tie");
    state = 3'b000;
    repeat (3) @(negedge clk);
    chk("sticky_done", 32'(done), 32'd1);
    chk("sticky_class", 32'(class_out), 32'd0);
    chk("sticky_wt_req", 32'(wt_req), 32'd0);

    // Class 7 matches exactly, all others fully inverted.
    do_reset();
    rand_feature();
    set_class7_match();
    load_mem();
    start_run(7, 196, 81);
    wait_done("class7");

    // Same data with two stall cycles before every accept.
    do_reset();
    stall_en = 1'b1;
    start_run(7, 196, 221);
    wait_done("class7_stall");
    stall_en = 1'b0;

    // Classes 3 and 5 tie at 150, the rest score 100.
    do_reset();
    rand_feature();
    set_tie_3_5();
    load_mem();
    start_run(3, 150, 81);
    wait_done("tie35");

    // Reset in the middle of class 4, then a full rerun.
    do_reset();
    set_class7_match();
    load_mem();
    start_run(7, 196, 81);
    void'(exp_q.pop_back());
    wait_addr("reach_class4", 4*NCHUNK + 2);
    rst = 1'b1;
    @(negedge clk);
    chk_zero_outputs("mid_reset");
    rst = 1'b0;
    start_run(7, 196, 81);
    wait_done("rerun");

    // Leave s_LAYER_3 during class 2, then re-enter.
    do_reset();
    set_tie_3_5();
    load_mem();
    start_run(3, 150, 81);
    void'(exp_q.pop_back());
    wait_addr("reach_class2", 2*NCHUNK + 1);
    state = 3'b011;
    @(negedge clk);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_wt_req", 32'(wt_req), 32'd0);
    chk("abort_class_out", 32'(class_out), 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_idle_wt_req", 32'(wt_req), 32'd0);
    start_run(3, 150, 81);
    wait_done("reentry");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
